// File: rtl/s2p.sv
// s2p: serial-to-parallel deserializer, NUM_ELEMENTS beats per vector.
// Fill buffer plus output register lets collection overlap a stalled output.
module s2p #(
    parameter int DATA_WIDTH   = 12,
    parameter int NUM_ELEMENTS = 5,
    localparam int COUNT_WIDTH = $clog2(NUM_ELEMENTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   s2p_ready_in,
    input  logic                   s2p_valid_in,
    input  logic [DATA_WIDTH-1:0]  s2p_serial_in,
    input  logic                   s2p_ready_out,
    output logic                   s2p_valid_out,
    output logic [DATA_WIDTH-1:0]  s2p_parallel_out [0:NUM_ELEMENTS-1],
    output logic [COUNT_WIDTH-1:0] s2p_count_out
);

    localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(NUM_ELEMENTS - 1);

    logic [DATA_WIDTH-1:0]  fill [0:NUM_ELEMENTS-1];
    logic [DATA_WIDTH-1:0]  out_q [0:NUM_ELEMENTS-1];
    logic [COUNT_WIDTH-1:0] idx;
    logic                   fill_full;
    logic                   valid_q;

    logic accept;
    logic final_beat;
    logic out_free;
    logic load_direct;
    logic load_drain;

    always_comb begin
        accept      = s2p_valid_in && !fill_full;
        final_beat  = accept && (idx == LAST);
        out_free    = !valid_q || s2p_ready_out;
        load_direct = final_beat && out_free;
        load_drain  = fill_full && out_free;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                fill[i] <= '0;
            end
        end else if (accept) begin
            fill[idx] <= s2p_serial_in;
        end
    end

    // Direct load bypasses the fill slot for the final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                out_q[i] <= '0;
            end
        end else if (load_direct) begin
            for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
                out_q[i] <= fill[i];
            end
            out_q[NUM_ELEMENTS-1] <= s2p_serial_in;
        end else if (load_drain) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                out_q[i] <= fill[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (accept) begin
            if (idx != LAST) begin
                idx <= idx + 1'b1;
            end else if (out_free) begin
                idx <= '0;
            end
        end else if (load_drain) begin
            idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_full <= 1'b0;
        end else if (final_beat && !out_free) begin
            fill_full <= 1'b1;
        end else if (load_drain) begin
            fill_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else if (load_direct || load_drain) begin
            valid_q <= 1'b1;
        end else if (s2p_ready_out) begin
            valid_q <= 1'b0;
        end
    end

    assign s2p_ready_in     = !fill_full;
    assign s2p_valid_out    = valid_q;
    assign s2p_parallel_out = out_q;
    assign s2p_count_out    = idx;

endmodule

// File: doc/s2p.md
Name: s2p

Overview:
- Serial-to-parallel deserializer: the receiving end of the p2s protocol. Collects NUM_ELEMENTS consecutive AXI-stream beats into one parallel vector and presents it on an AXI-style output.
- Used to rebuild per-channel vectors from serial MAC/conv outputs before dense and pooling stages.
- Double-buffered (fill buffer plus output register), so collection of the next vector continues while the previous one waits for downstream.

Parameters:
- DATA_WIDTH, 12, width of each serial element.
- NUM_ELEMENTS, 5, beats per parallel vector; must be >= 2.
- COUNT_WIDTH, clog2(NUM_ELEMENTS) from cnn1d_pkg (localparam), width of the fill index.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- s2p_ready_in  output  1  block can accept a serial beat.
- s2p_valid_in  input  1  serial beat valid.
- s2p_serial_in  input  DATA_WIDTH  serial element.
- s2p_ready_out  input  1  downstream accepts the vector.
- s2p_valid_out  output  1  parallel vector valid.
- s2p_parallel_out  output  DATA_WIDTH x [0:NUM_ELEMENTS-1]  unpacked output vector.
- s2p_count_out  output  COUNT_WIDTH  number of elements currently held in the fill buffer (debug/status).

Behaviour:
- Reset (rst=0, asynchronous):
  - fill index = 0, fill_full = 0, s2p_valid_out = 0.
  - All s2p_parallel_out elements = 0; fill buffer = 0; s2p_count_out = 0.
  - s2p_ready_in = 1 after reset deasserts.
- Input handshake:
  - A beat is accepted when s2p_valid_in && s2p_ready_in at a rising edge.
  - s2p_ready_in = !fill_full. It is a registered state only, with no combinational path from s2p_ready_out or s2p_valid_in.
- Element ordering: the k-th accepted beat of a vector (k = 0..NUM_ELEMENTS-1) lands at index k. The first beat maps to s2p_parallel_out[0].
- Non-final beat (index < NUM_ELEMENTS-1): write the fill buffer at index, then index++.
- Final beat (index == NUM_ELEMENTS-1), with out_free = !s2p_valid_out || s2p_ready_out:
  - If out_free: s2p_parallel_out loads fill[0..N-2] plus the current beat at [N-1]. s2p_valid_out = 1 next cycle; index wraps to 0. Latency is 1 cycle from final beat to valid_out.
  - Else: store the beat, set fill_full = 1, index holds at NUM_ELEMENTS-1 (count reports NUM_ELEMENTS-1). s2p_ready_in drops the next cycle.
- Full drain: when fill_full && out_free:
  - Transfer the fill buffer to the output register and set s2p_valid_out = 1.
  - Clear fill_full and set index = 0. s2p_ready_in rises the next cycle.
- Output handshake:
  - s2p_valid_out && s2p_ready_out clears s2p_valid_out unless a new transfer occurs in the same cycle. Simultaneous consume and load leaves valid_out = 1 with the new data.
  - s2p_parallel_out is stable while s2p_valid_out=1 && s2p_ready_out=0.
- Throughput: with s2p_ready_out held high, one vector per NUM_ELEMENTS input cycles with no bubbles. s2p_ready_in never drops.
- s2p_valid_in low holds state; gaps between beats are allowed anywhere in a vector.
- Data is passed through unmodified; no arithmetic or sign handling.
- Reset mid-vector discards the partial vector and any pending output.

Test Plan:
- Basic order: N=5, DW=12, ready_out=1. Send beats 0x001..0x005 back-to-back → one cycle after the 5th beat, valid_out=1 and parallel_out = {0x001,0x002,0x003,0x004,0x005}. valid_out is low the following cycle.
- Streaming: send 20 consecutive beats 1..20 with ready_out=1 → 4 vectors {1..5},{6..10},{11..15},{16..20}. ready_in stays 1 throughout; each valid_out pulse occurs 1 cycle after every 5th beat.
- Backpressure: ready_out=0, send 10 beats →
  - Vector 1 is held on the output.
  - After the 10th beat, ready_in=0 and count_out=4.
  - Assert ready_out for 1 cycle → vector 1 is consumed and vector 2 loads in the same cycle (valid_out stays 1); ready_in=1 the next cycle.
- Gapped input: beats 0xABC,0x123 with 3 idle cycles between each of 5 beats → count_out increments 0→1→2→3→4 on accepts only. Output is correct when the 5th beat is accepted.
- Reset mid-vector: accept 3 beats, pulse rst low for 1 cycle (async, mid-cycle) → valid_out=0, outputs 0, count_out=0 immediately. The next 5 beats form a clean vector.
- Stability: hold ready_out=0 with valid_out=1 for 10 cycles while the input toggles → parallel_out is unchanged. ready_in drops once the fill buffer is full.
